count_seq: RTL and testbench
============================

COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and data width in bits.
REQ-002 SHALL have parameter REPW, default 2, repeat-count field width in bits.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CMD_VALID  input  1  command offered.
REQ-006 SHALL have port CMD_READY  output  1  controller accepts a command this cycle.
REQ-007 SHALL have port CMD_START  input  WIDTH  counter value to load at the start of each pass.
REQ-008 SHALL have port CMD_END  input  WIDTH  terminal value that ends each pass.
REQ-009 SHALL have port CMD_UD  input  1  1 = count up, 0 = count down.
REQ-010 SHALL have port CMD_REPS  input  REPW  extra passes after the first; total passes = CMD_REPS+1.
REQ-011 SHALL have port DOUT  output  WIDTH  current counter value.
REQ-012 SHALL have port BUSY  output  1  high in LOAD and RUN states.
REQ-013 SHALL have port WRAP  output  1  one-cycle pulse on any counter wrap (max->0 up, 0->max down).
REQ-014 SHALL have port DONE  output  1  one-cycle pulse after the last pass completes.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: CMD_READY=1; on CMD_VALID&&CMD_READY, capture START/END/UD/REPS into registers, go LOAD.
REQ-017 CMD_READY SHALL be 0 in every state other than IDLE; commands offered then are held off, not dropped.
REQ-018 LOAD: counter loads captured START on this edge, so DOUT=START in the next cycle; go RUN.
REQ-019 RUN: if DOUT==END, the pass ends: with reps_left==0 go DONE; otherwise decrement reps_left and go LOAD.
REQ-020 RUN: if DOUT!=END, the counter steps by one in direction UD, modulo 2^WIDTH.
REQ-021 START==END SHALL give a pass of exactly one RUN cycle with no step.
REQ-022 Pass length SHALL be 1 + steps from START to END, modulo 2^WIDTH in direction UD; wrap is legal mid-pass.
REQ-023 WRAP SHALL assert in the cycle after a wrapping step, i.e. coincident with DOUT showing the wrapped value.
REQ-024 DONE: DONE=1 for one cycle, then go IDLE; DOUT holds its last value in DONE and IDLE.
REQ-025 The counter SHALL hold its value in IDLE and DONE.
REQ-026 Capture registers SHALL change only on an accepted handshake.

Reset
REQ-027 RST=1 SHALL asynchronously force state=IDLE, DOUT=0, reps_left=0, captured fields=0, WRAP=0, DONE=0, BUSY=0.
REQ-028 CMD_READY SHALL read 1 while RST=1.
REQ-029 Reset asserted mid-pass SHALL abort the command; no DONE pulse follows.

Configuration
REQ-030 Macro COUNT_SEQ_ABORT_EN SHALL, when defined, add input ABORT (1 bit).
REQ-031 With COUNT_SEQ_ABORT_EN: ABORT=1 in LOAD or RUN goes to DONE on the next edge, DONE pulses, and DOUT freezes.
REQ-032 With COUNT_SEQ_ABORT_EN: ABORT is ignored in IDLE and DONE.
REQ-033 With COUNT_SEQ_ABORT_EN: ABORT wins over a simultaneous END match or reload.
REQ-034 Without COUNT_SEQ_ABORT_EN: no ABORT port, and behaviour per REQ-015..026 only.

Structure
REQ-035 Package count_seq_pkg SHALL hold the state enum type and default WIDTH/REPW constants.
REQ-036 Sub-module count_core SHALL contain the WIDTH-bit up/down counter: async reset, load, enable, UD, wrap flag.
REQ-037 count_seq SHALL contain the FSM, capture registers and repeat counter.

Verification
REQ-038 Scenario: START=3, END=6, UD=1, REPS=0 -> DOUT 3,4,5,6 over four RUN cycles; one DONE pulse; WRAP never asserts.
REQ-039 Scenario: START=1, END=14, UD=0, REPS=0 -> DOUT 1,0,15,14; WRAP asserts with DOUT=15; then DONE.
REQ-040 Scenario: START=END=9, REPS=2 -> three LOAD/RUN pairs of one RUN cycle each; DONE after the third.
REQ-041 Scenario: CMD_VALID held high through a command -> a second command is accepted only in IDLE after DONE; CMD_READY=0 while BUSY.
REQ-042 Scenario: RST asserted asynchronously between edges with DOUT=5 in RUN -> DOUT=0, state IDLE, CMD_READY=1 immediately, no DONE.
REQ-043 Scenario: with COUNT_SEQ_ABORT_EN, ABORT in the second RUN cycle of START=0, END=10 -> DOUT frozen at 1, single DONE, then IDLE.

Source files
------------

// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
// Shared definitions for the count_seq controller and its counter core:
// the controller state encoding and the default counter / repeat widths.
// ---------------------------------------------------------------------------
package count_seq_pkg;

  // Default counter/data width in bits.
  localparam int DEF_WIDTH = 4;

  // Default width of the repeat-count field in bits.
  localparam int DEF_REPW  = 2;

  // Controller states. LOAD and RUN are the busy states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_core.sv
// ---------------------------------------------------------------------------
// count_core
// WIDTH-bit up/down counter with synchronous load and enable, plus a
// registered wrap flag that is high in the cycle the counter shows a
// wrapped value (max->0 counting up, 0->max counting down).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (count=0, wrap=0)
//   i_load     in   load i_loadVal on the next edge (has priority over i_en)
//   i_loadVal  in   WIDTH  value to load
//   i_en       in   step by one on the next edge
//   i_ud       in   1 = count up, 0 = count down
//   o_count    out  WIDTH  current counter value
//   o_wrap     out  wrap flag for the value currently on o_count
// ---------------------------------------------------------------------------
module count_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_en,
  input  logic             i_ud,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  // The counter register. The wrap flag is registered together with the
  // step that causes it, so it lines up with the wrapped value on o_count.
  // Any cycle that does not step (hold or load) clears the flag again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_load) begin
        r_count <= i_loadVal;
      end else if (i_en) begin
        if (i_ud) begin
          r_count <= r_count + 1'b1;
          r_wrap  <= &r_count;
        end else begin
          r_count <= r_count - 1'b1;
          r_wrap  <= ~|r_count;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/count_seq.sv
// ---------------------------------------------------------------------------
// count_seq
// Command-driven counting sequencer. A command (start, end, direction,
// repeat count) is accepted in IDLE; the counter then runs one or more
// passes from start to end (modulo 2^WIDTH), reloading start between passes,
// and pulses DONE after the last pass.
//
// Optional feature: define COUNT_SEQ_ABORT_EN to add the ABORT input, which
// ends a command early from LOAD or RUN with the counter frozen.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   CMD_VALID  in   command offered
//   CMD_READY  out  command accepted this cycle (high only in IDLE / reset)
//   CMD_START  in   WIDTH  value loaded at the start of each pass
//   CMD_END    in   WIDTH  terminal value of each pass
//   CMD_UD     in   1 = count up, 0 = count down
//   CMD_REPS   in   REPW   extra passes after the first
//   ABORT      in   (COUNT_SEQ_ABORT_EN only) abort the running command
//   DOUT       out  WIDTH  current counter value
//   BUSY       out  high in LOAD and RUN
//   WRAP       out  one-cycle pulse with the wrapped counter value
//   DONE       out  one-cycle pulse after the command completes
// ---------------------------------------------------------------------------
module count_seq
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REPW  = DEF_REPW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_START,
  input  logic [WIDTH-1:0] CMD_END,
  input  logic             CMD_UD,
  input  logic [REPW-1:0]  CMD_REPS,
`ifdef COUNT_SEQ_ABORT_EN
  input  logic             ABORT,
`endif
  output logic [WIDTH-1:0] DOUT,
  output logic             BUSY,
  output logic             WRAP,
  output logic             DONE
);

  state_t           r_state;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_end;
  logic             r_ud;
  logic [REPW-1:0]  r_repsLeft;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_dout;
  logic             w_abort;
  logic             w_endHit;
  logic             w_load;
  logic             w_en;

  // Abort only matters while a command is in flight; in IDLE and DONE it is
  // simply not looked at. Without the feature the term is tied off.
`ifdef COUNT_SEQ_ABORT_EN
  assign w_abort = ABORT && ((r_state == ST_LOAD) || (r_state == ST_RUN));
`else
  assign w_abort = 1'b0;
`endif

  // Counter control. The end-of-pass compare uses the value already on
  // DOUT, so a pass where start equals end spends one RUN cycle and never
  // steps. Abort suppresses both load and step so DOUT freezes.
  assign w_endHit = (r_state == ST_RUN) && (w_dout == r_end);
  assign w_load   = (r_state == ST_LOAD) && !w_abort;
  assign w_en     = (r_state == ST_RUN) && !w_endHit && !w_abort;

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (CLK),
    .rst      (RST),
    .i_load   (w_load),
    .i_loadVal(r_start),
    .i_en     (w_en),
    .i_ud     (r_ud),
    .o_count  (w_dout),
    .o_wrap   (WRAP)
  );

  // Controller FSM with capture registers and the remaining-pass counter.
  // BUSY and DONE are registered alongside the state so they change on the
  // same edge as the state they describe. Capture registers only move on an
  // accepted handshake, so a command held on the bus while busy cannot
  // disturb the one being executed; it is simply accepted once back in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_start    <= '0;
      r_end      <= '0;
      r_ud       <= 1'b0;
      r_repsLeft <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (CMD_VALID) begin
            r_start    <= CMD_START;
            r_end      <= CMD_END;
            r_ud       <= CMD_UD;
            r_repsLeft <= CMD_REPS;
            r_busy     <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_endHit) begin
            if (r_repsLeft == '0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_repsLeft <= r_repsLeft - 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is decoded straight from the state so it reads high during reset,
  // when the state is being held in IDLE.
  assign CMD_READY = (r_state == ST_IDLE);
  assign DOUT      = w_dout;
  assign BUSY      = r_busy;
  assign DONE      = r_done;

endmodule

// File: tb/tb_count_seq.sv
// ---------------------------------------------------------------------------
// tb_count_seq
// Directed testbench for count_seq (WIDTH=4, REPW=2). Define
// COUNT_SEQ_ABORT_EN to also exercise the ABORT input.
// ---------------------------------------------------------------------------
module tb_count_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [3:0] CMD_START = '0;
  logic [3:0] CMD_END = '0;
  logic       CMD_UD = 1'b0;
  logic [1:0] CMD_REPS = '0;
`ifdef COUNT_SEQ_ABORT_EN
  logic       ABORT = 1'b0;
`endif
  logic [3:0] DOUT;
  logic       BUSY;
  logic       WRAP;
  logic       DONE;

  int passCount = 0;
  int checkCount = 0;

  logic [3:0] expDout [0:15];
  logic       expWrap [0:15];

  count_seq #(
    .WIDTH(4),
    .REPW (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_START(CMD_START),
    .CMD_END  (CMD_END),
    .CMD_UD   (CMD_UD),
    .CMD_REPS (CMD_REPS),
`ifdef COUNT_SEQ_ABORT_EN
    .ABORT    (ABORT),
`endif
    .DOUT     (DOUT),
    .BUSY     (BUSY),
    .WRAP     (WRAP),
    .DONE     (DONE)
  );

  // Free-running 10-time-unit clock.
  always #5 CLK = ~CLK;

  // Advance to 1 unit after the next rising edge, where outputs are stable
  // and inputs may be changed for the following edge.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Offer one command for exactly one accepting edge. With hold set, the
  // command stays valid afterwards so the caller can test hold-off.
  task automatic applyStimulus(input logic [3:0] start, input logic [3:0] stop,
                               input logic ud, input logic [1:0] reps,
                               input logic hold);
    CMD_START = start;
    CMD_END   = stop;
    CMD_UD    = ud;
    CMD_REPS  = reps;
    CMD_VALID = 1'b1;
    checkOutput("ready_before_cmd", CMD_READY, 1);
    step;
    if (!hold) CMD_VALID = 1'b0;
    checkOutput("busy_in_load", BUSY, 1);
    checkOutput("ready_in_load", CMD_READY, 0);
  endtask

  // Walk n RUN cycles against expDout/expWrap, then the DONE cycle and the
  // return to IDLE, where DOUT must hold the last value.
  task automatic runExpect(input int n);
    for (int i = 0; i < n; i++) begin
      step;
      checkOutput("run_dout", DOUT, expDout[i]);
      checkOutput("run_wrap", WRAP, expWrap[i]);
      checkOutput("run_busy", BUSY, 1);
      checkOutput("run_done", DONE, 0);
    end
    step;
    checkOutput("done_pulse", DONE, 1);
    checkOutput("done_busy", BUSY, 0);
    checkOutput("done_ready", CMD_READY, 0);
    checkOutput("done_dout_hold", DOUT, expDout[n-1]);
    step;
    checkOutput("idle_done_low", DONE, 0);
    checkOutput("idle_ready", CMD_READY, 1);
    checkOutput("idle_dout_hold", DOUT, expDout[n-1]);
  endtask

  initial begin
    // Reset state, including ready high while reset is asserted.
    #2;
    checkOutput("rst_dout", DOUT, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_wrap", WRAP, 0);
    checkOutput("rst_done", DONE, 0);
    checkOutput("rst_ready", CMD_READY, 1);
    step;
    RST = 1'b0;
    step;

    // Up count 3..6, no wrap.
    applyStimulus(4'd3, 4'd6, 1'b1, 2'd0, 1'b0);
    expDout[0] = 4'd3; expDout[1] = 4'd4; expDout[2] = 4'd5; expDout[3] = 4'd6;
    for (int i = 0; i < 4; i++) expWrap[i] = 1'b0;
    runExpect(4);

    // Down count 1..14 through zero; wrap seen with DOUT=15.
    applyStimulus(4'd1, 4'd14, 1'b0, 2'd0, 1'b0);
    expDout[0] = 4'd1; expDout[1] = 4'd0; expDout[2] = 4'd15; expDout[3] = 4'd14;
    expWrap[0] = 1'b0; expWrap[1] = 1'b0; expWrap[2] = 1'b1; expWrap[3] = 1'b0;
    runExpect(4);

    // Up count 14..1 through max; wrap seen with DOUT=0.
    applyStimulus(4'd14, 4'd1, 1'b1, 2'd0, 1'b0);
    expDout[0] = 4'd14; expDout[1] = 4'd15; expDout[2] = 4'd0; expDout[3] = 4'd1;
    expWrap[0] = 1'b0; expWrap[1] = 1'b0; expWrap[2] = 1'b1; expWrap[3] = 1'b0;
    runExpect(4);

    // Start equals end with two repeats: three one-cycle passes.
    applyStimulus(4'd9, 4'd9, 1'b1, 2'd2, 1'b0);
    for (int p = 0; p < 3; p++) begin
      step;
      checkOutput("rep_run_dout", DOUT, 9);
      checkOutput("rep_run_done", DONE, 0);
      if (p < 2) begin
        step;
        checkOutput("rep_load_busy", BUSY, 1);
        checkOutput("rep_load_done", DONE, 0);
      end
    end
    step;
    checkOutput("rep_done_pulse", DONE, 1);
    step;
    checkOutput("rep_idle_done", DONE, 0);

    // Valid held through a command; the second command waits for IDLE and
    // changing the bus mid-command must not alter the running one.
    applyStimulus(4'd2, 4'd4, 1'b1, 2'd0, 1'b1);
    CMD_START = 4'd7;
    CMD_END   = 4'd7;
    CMD_UD    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checkOutput("hold_dout", DOUT, 2 + i);
      checkOutput("hold_ready", CMD_READY, 0);
    end
    step;
    checkOutput("hold_done", DONE, 1);
    checkOutput("hold_done_ready", CMD_READY, 0);
    step;
    checkOutput("hold_idle_ready", CMD_READY, 1);
    step;
    CMD_VALID = 1'b0;
    checkOutput("second_busy", BUSY, 1);
    step;
    checkOutput("second_dout", DOUT, 7);
    step;
    checkOutput("second_done", DONE, 1);
    step;

    // Asynchronous reset mid-pass with DOUT=5.
    applyStimulus(4'd3, 4'd8, 1'b1, 2'd0, 1'b0);
    step;
    step;
    step;
    checkOutput("pre_rst_dout", DOUT, 5);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("async_rst_dout", DOUT, 0);
    checkOutput("async_rst_ready", CMD_READY, 1);
    checkOutput("async_rst_busy", BUSY, 0);
    step;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checkOutput("post_rst_done", DONE, 0);
      checkOutput("post_rst_busy", BUSY, 0);
      checkOutput("post_rst_dout", DOUT, 0);
    end

`ifdef COUNT_SEQ_ABORT_EN
    // Abort in the second RUN cycle of 0..10: DOUT freezes at 1.
    applyStimulus(4'd0, 4'd10, 1'b1, 2'd0, 1'b0);
    step;
    checkOutput("abort_run1", DOUT, 0);
    step;
    checkOutput("abort_run2", DOUT, 1);
    ABORT = 1'b1;
    step;
    ABORT = 1'b0;
    checkOutput("abort_done", DONE, 1);
    checkOutput("abort_dout", DOUT, 1);
    checkOutput("abort_busy", BUSY, 0);
    step;
    checkOutput("abort_idle_done", DONE, 0);
    checkOutput("abort_idle_dout", DOUT, 1);
    checkOutput("abort_idle_ready", CMD_READY, 1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
